// File: rtl/fd_pipe_ce.sv
// Elastic register pipeline with bubble collapse and a global clock enable.
// Define FD_PIPE_CNT_EN to add the registered stage-occupancy output CNT.

module fd_pipe_ce_stage #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             adv,
  input  logic             uv,
  input  logic [WIDTH-1:0] ud,
  output logic             val,
  output logic [WIDTH-1:0] data
);
  // Data only loads under a valid upstream so an empty advance keeps the old word.
  always_ff @(posedge C) begin
    if (CLR) begin
      val  <= 1'b0;
      data <= '0;
    end else if (adv) begin
      val <= uv;
      if (uv) data <= ud;
    end
  end
endmodule

module fd_pipe_ce #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             DV,
  input  logic [WIDTH-1:0] D,
  output logic             DR,
  output logic             QV,
  output logic [WIDTH-1:0] Q,
  input  logic             QR
`ifdef FD_PIPE_CNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] CNT
`endif
);
  logic [DEPTH-1:0]            val, adv, uv;
  logic [DEPTH-1:0][WIDTH-1:0] data, ud;

  // Ready ripples back from the output so empty stages absorb stalls.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == DEPTH-1) begin : g_last
      assign adv[i] = CE & (~val[i] | QR);
    end else begin : g_mid
      assign adv[i] = CE & (~val[i] | adv[i+1]);
    end
    if (i == 0) begin : g_head
      assign uv[i] = DV;
      assign ud[i] = D;
    end else begin : g_body
      assign uv[i] = val[i-1];
      assign ud[i] = data[i-1];
    end
  end

  fd_pipe_ce_stage #(.WIDTH(WIDTH)) u_stg [DEPTH-1:0] (
    .C    (C),
    .CLR  (CLR),
    .adv  (adv),
    .uv   (uv),
    .ud   (ud),
    .val  (val),
    .data (data)
  );

  assign DR = adv[0] & ~CLR;
  assign QV = val[DEPTH-1];
  assign Q  = data[DEPTH-1];

`ifdef FD_PIPE_CNT_EN
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] val_nxt;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    val_nxt = '0;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      val_nxt[i] = adv[i] ? uv[i] : val[i];
      cnt_nxt    = cnt_nxt + CW'(val_nxt[i]);
    end
  end

  always_ff @(posedge C) begin
    if (CLR) CNT <= '0;
    else     CNT <= cnt_nxt;
  end
`endif
endmodule

// File: tb/tb_fd_pipe_ce.sv
// Bench for fd_pipe_ce: DEPTH=2 and DEPTH=3 instances on shared stimulus,
// checked each cycle against a word/position queue model plus directed literals.
`timescale 1ns/1ps
module tb_fd_pipe_ce;
  logic       C = 1'b0;
  logic       CLR, CE, DV, QR;
  logic [3:0] D;
  logic       dr [2];
  logic       qv [2];
  logic [3:0] q  [2];
`ifdef FD_PIPE_CNT_EN
  logic [1:0] cnt [2];
`endif

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 C = ~C;

  fd_pipe_ce #(.WIDTH(4), .DEPTH(2)) dut2 (
    .C(C), .CLR(CLR), .CE(CE), .DV(DV), .D(D), .DR(dr[0]), .QV(qv[0]), .Q(q[0]), .QR(QR)
`ifdef FD_PIPE_CNT_EN
    , .CNT(cnt[0])
`endif
  );

  fd_pipe_ce #(.WIDTH(4), .DEPTH(3)) dut3 (
    .C(C), .CLR(CLR), .CE(CE), .DV(DV), .D(D), .DR(dr[1]), .QV(qv[1]), .Q(q[1]), .QR(QR)
`ifdef FD_PIPE_CNT_EN
    , .CNT(cnt[1])
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: ordered list of words in flight, each with a stage position.
  int dep [2] = '{2, 3};
  int md [2][16];
  int mp [2][16];
  int np [2][16];
  int mn [2] = '{0, 0};
  int mlast [2] = '{0, 0};
  bit mpop [2];
  bit mroom [2];

  // Oldest word leaves if at the end and QR; others move up one unless blocked.
  task automatic mmove(input int k);
    int lim;
    lim = dep[k];
    mpop[k] = 0;
    for (int i = 0; i < mn[k]; i++) begin
      if (i == 0 && mp[k][0] == dep[k]-1) begin
        if (QR) mpop[k] = 1;
        else begin np[k][0] = mp[k][0]; lim = mp[k][0]; end
      end else begin
        np[k][i] = (mp[k][i]+1 < lim-1) ? mp[k][i]+1 : lim-1;
        lim = np[k][i];
      end
    end
    mroom[k] = (lim >= 1);
  endtask

  task automatic mcommit(input int k);
    int j;
    int nd [16];
    int npn [16];
    j = 0;
    if (CLR) begin
      mn[k] = 0;
      mlast[k] = 0;
    end else if (CE) begin
      mmove(k);
      for (int i = 0; i < mn[k]; i++) begin
        if (!(i == 0 && mpop[k])) begin
          nd[j] = md[k][i];
          npn[j] = np[k][i];
          if (np[k][i] == dep[k]-1 && mp[k][i] != dep[k]-1) mlast[k] = md[k][i];
          j++;
        end
      end
      if (DV && mroom[k]) begin
        nd[j] = int'(D);
        npn[j] = 0;
        if (dep[k] == 1) mlast[k] = int'(D);
        j++;
      end
      for (int i = 0; i < j; i++) begin
        md[k][i] = nd[i];
        mp[k][i] = npn[i];
      end
      mn[k] = j;
    end
  endtask

  always @(posedge C) begin
    mcommit(0);
    mcommit(1);
  end

  always @(negedge C) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        mmove(k);
        chk($sformatf("dr_d%0d", dep[k]), int'(dr[k]), int'(CE && !CLR && mroom[k]));
        chk($sformatf("qv_d%0d", dep[k]), int'(qv[k]), int'(mn[k] > 0 && mp[k][0] == dep[k]-1));
        chk($sformatf("q_d%0d", dep[k]), int'(q[k]), mlast[k]);
`ifdef FD_PIPE_CNT_EN
        chk($sformatf("cnt_d%0d", dep[k]), int'(cnt[k]), mn[k]);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    CLR = 1; CE = 1; DV = 0; QR = 1; D = 4'h0;
    tick();
    started = 1;
    #1 chk("dr_during_clr", int'(dr[0]), 0);
    tick();
    chk("reset_qv", int'(qv[0]), 0);
    chk("reset_q", int'(q[0]), 0);
    CLR = 0;

    // single word
    DV = 1; D = 4'hA;
    tick();
    DV = 0;
    chk("single_qv_e1", int'(qv[0]), 0);
    tick();
    chk("single_qv_e2", int'(qv[0]), 1);
    chk("single_q_e2", int'(q[0]), 10);
    tick();
    chk("single_qv_e3", int'(qv[0]), 0);

    // streaming 0..7
    for (int i = 0; i < 8; i++) begin
      DV = 1; D = 4'(i);
      #1 chk("stream_dr", int'(dr[0]), 1);
      tick();
      if (i >= 1) begin
        chk("stream_q", int'(q[0]), i-1);
        chk("stream_qv", int'(qv[0]), 1);
      end
    end
    DV = 0;
    tick();
    chk("stream_q_last", int'(q[0]), 7);
    tick();
    chk("stream_drained", int'(qv[0]), 0);
    tick();

    // backpressure
    QR = 0; DV = 1; D = 4'h1;
    tick();
    D = 4'h2;
    tick();
    DV = 0;
    #1 chk("bp_dr", int'(dr[0]), 0);
    chk("bp_q", int'(q[0]), 1);
`ifdef FD_PIPE_CNT_EN
    chk("bp_cnt", int'(cnt[0]), 2);
`endif
    QR = 1;
    tick();
    chk("bp_q2", int'(q[0]), 2);
    tick();
    chk("bp_empty", int'(qv[0]), 0);
    tick(); tick();

    // stall mid-stream
    DV = 1; D = 4'h0; tick();
    D = 4'h1; tick();
    D = 4'h2; tick();
    chk("stall_pre_q", int'(q[0]), 1);
    CE = 0; D = 4'hF;
    for (int i = 0; i < 3; i++) begin
      QR = i[0];
      #1 chk("stall_dr", int'(dr[0]), 0);
      tick();
      chk("stall_q", int'(q[0]), 1);
      chk("stall_qv", int'(qv[0]), 1);
    end
    CE = 1; QR = 1; D = 4'h3;
    tick();
    chk("resume_q2", int'(q[0]), 2);
    DV = 0;
    tick();
    chk("resume_q3", int'(q[0]), 3);
    tick();
    chk("resume_empty", int'(qv[0]), 0);
    tick(); tick();

    // bubble collapse on DEPTH=3
    QR = 0; DV = 1; D = 4'h5;
    #1 chk("bub_dr0", int'(dr[1]), 1);
    tick();
    DV = 0;
    #1 chk("bub_dr1", int'(dr[1]), 1);
    tick();
    DV = 1; D = 4'h6;
    #1 chk("bub_dr2", int'(dr[1]), 1);
    tick();
    DV = 0;
    chk("bub_qv_e3", int'(qv[1]), 1);
    chk("bub_q_e3", int'(q[1]), 5);
    #1 chk("bub_dr3", int'(dr[1]), 1);
    tick();
    chk("bub_q_e4", int'(q[1]), 5);
`ifdef FD_PIPE_CNT_EN
    chk("bub_cnt_e4", int'(cnt[1]), 2);
`endif

    // reset with the DEPTH=2 pipe full and CE low
    chk("full_before_clr", int'(qv[0]), 1);
    CE = 0; CLR = 1; DV = 1; QR = 1;
    #1 chk("clr_dr_d2", int'(dr[0]), 0);
    chk("clr_dr_d3", int'(dr[1]), 0);
    tick();
    chk("clr_qv_d2", int'(qv[0]), 0);
    chk("clr_q_d2", int'(q[0]), 0);
    chk("clr_qv_d3", int'(qv[1]), 0);
    chk("clr_q_d3", int'(q[1]), 0);
`ifdef FD_PIPE_CNT_EN
    chk("clr_cnt_d2", int'(cnt[0]), 0);
`endif
    CLR = 0; CE = 1; DV = 1; D = 4'h9;
    tick();
    DV = 0;
    tick(); tick(); tick();

    @(negedge C);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fd_pipe_ce.md
FD_PIPE_CE -- requirements
Module: fd_pipe_ce

Interface
REQ-001 Parameter WIDTH, default 4, sets the data width in bits; legal values are 1 and above.
REQ-002 Parameter DEPTH, default 2, sets the number of register stages; legal values are 1 and above.
REQ-003 Port C, input, 1 bit, is the clock; all state SHALL change on its rising edge only.
REQ-004 Port CLR, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port CE, input, 1 bit, SHALL be the global clock enable; at 0 the block stalls.
REQ-006 Port DV, input, 1 bit, SHALL mark D as valid on the input side.
REQ-007 Port D, input, WIDTH bits, SHALL carry the input data word.
REQ-008 Port DR, output, 1 bit, SHALL signal input-side ready; it is combinational.
REQ-009 Port QV, output, 1 bit, SHALL signal output valid; it is registered.
REQ-010 Port Q, output, WIDTH bits, SHALL carry the output data word; it is registered.
REQ-011 Port QR, input, 1 bit, SHALL signal downstream ready.
REQ-012 Port CNT, output, clog2(DEPTH+1) bits, SHALL give the stage occupancy; it exists only under FD_PIPE_CNT_EN.

Function
REQ-013 Each stage i (0..DEPTH-1) SHALL hold a data register data[i] and a valid bit val[i]; stage DEPTH-1 drives the outputs: Q=data[DEPTH-1], QV=val[DEPTH-1].
REQ-014 Advance enables SHALL be computed as follows:
- adv[DEPTH-1] = CE & (~val[DEPTH-1] | QR)
- adv[i] = CE & (~val[i] | adv[i+1]), for i < DEPTH-1
REQ-015 DR SHALL equal adv[0] & ~CLR.
REQ-016 An input transfer SHALL occur when DV & DR; an output transfer SHALL occur when QV & QR & CE.
REQ-017 On a rising edge with adv[i]=1:
- val[i] SHALL load the upstream valid (DV for i=0, else val[i-1]).
- data[i] SHALL load the upstream data only if that upstream valid is 1; otherwise data[i] holds.
REQ-018 When adv[i]=0, stage i SHALL hold both data[i] and val[i].
REQ-019 Bubbles SHALL collapse: a valid stage SHALL advance into an empty downstream stage even while QR=0.
REQ-020 Latency through an empty pipe SHALL be DEPTH edges from the input transfer to QV=1; throughput SHALL be 1 word per cycle with QR=1 and CE=1.
REQ-021 Words SHALL never be dropped, duplicated or reordered; DV/D changing while DR=0 SHALL have no effect.
REQ-022 When all stages are valid and QR=0, DR SHALL be 0.
REQ-023 When all stages are valid and QR=1, simultaneous input and output transfers SHALL both occur in the same cycle.
REQ-024 When CE=0, the block SHALL show:
- no state change
- DR=0
- no transfers, regardless of DV and QR

Reset
REQ-025 When CLR=1 at a rising edge, all val[i] SHALL become 0 and all data[i] SHALL become 0, so Q=0, QV=0 and CNT=0.
REQ-026 CLR SHALL take priority over CE, DV and QR.
REQ-027 Reset SHALL be effective mid-operation: words in flight are discarded and no output transfer is counted on the reset edge.
REQ-028 DR SHALL be 0 throughout any cycle in which CLR=1.

Configuration
REQ-029 Macro FD_PIPE_CNT_EN SHALL control the occupancy counter.
- Defined: port CNT exists and is a register equal to the number of set val[i] after each edge, with range 0..DEPTH.
- Not defined: port CNT and its logic are absent; all other behaviour is identical.

Verification
REQ-030 Single word: WIDTH=4, DEPTH=2, CE=1, QR=1, DV=1 with D=0xA for one cycle -> QV=1 and Q=0xA after edge 2, for exactly one cycle; QV=0 afterwards.
REQ-031 Streaming: D=0..7 on 8 consecutive cycles with DV=1 and QR=1 -> Q shows 0..7 on 8 consecutive cycles starting after edge 2, with DR=1 throughout.
REQ-032 Backpressure: QR=0, DV=1, D=0x1 then 0x2 -> after 2 edges DR=0 and CNT=2; then QR=1 -> Q=0x1, then Q=0x2, then QV=0.
REQ-033 Stall: CE=0 for 3 cycles mid-stream -> Q, QV and CNT frozen, DR=0, no transfers; the stream resumes intact when CE=1.
REQ-034 Bubble collapse: DEPTH=3, QR=0, word 0x5 followed 2 cycles later by 0x6 -> 0x5 sits in stage 2 after edge 3 and 0x6 sits in stage 1 after edge 4 (CNT=2); DR stays 1.
REQ-035 Reset: pipe full, CE=0, CLR=1 for one edge -> QV=0, Q=0, CNT=0 after that edge; DR=0 during the CLR cycle.
